// File: rtl/hall_speed_meter_pkg.sv
// Shared definitions for the hall speed meter: hall code to sector decode,
// sector arithmetic helpers, FSM state encoding and history depth.
package hall_speed_meter_pkg;

    localparam logic [2:0]  SECTOR_UNKNOWN = 3'd7;
    // One electrical revolution spans six commutation intervals.
    localparam int unsigned SUM_DEPTH      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,   // no reference edge held
        ST_SYNC,   // reference edge held, interval not yet known
        ST_RUN     // intervals being reported
    } state_e;

    // {C,B,A} -> sector 0..5; 000 and 111 map to SECTOR_UNKNOWN.
    function automatic logic [2:0] hall_decode(input logic [2:0] hall);
        logic [2:0] sector;
        case (hall)
            3'b001:  sector = 3'd0;
            3'b011:  sector = 3'd1;
            3'b010:  sector = 3'd2;
            3'b110:  sector = 3'd3;
            3'b100:  sector = 3'd4;
            3'b101:  sector = 3'd5;
            default: sector = SECTOR_UNKNOWN;
        endcase
        return sector;
    endfunction

    function automatic logic [2:0] sector_next(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] sector_prev(input logic [2:0] s);
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

endpackage

// File: rtl/hall_speed_meter_period_sum6.sv
// period_sum6: six-deep period history with a running sum.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_flush        : discard the whole history (sum and fill to zero)
//   i_push         : shift i_period in; applied after a same-cycle flush
//   i_period       : period value to push
//   o_sum          : sum of the periods currently held
//   o_full         : high while six periods are held
module period_sum6
    import hall_speed_meter_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic [CNT_W-1:0]   i_period,
    output logic [CNT_W+2:0]   o_sum,
    output logic               o_full
);

    localparam int unsigned SUM_W  = CNT_W + 3;
    localparam logic [2:0]  FULL_C = 3'(SUM_DEPTH);

    // hist[0] is the newest period, hist[SUM_DEPTH-1] the oldest.
    logic [SUM_DEPTH-1:0][CNT_W-1:0] hist_q, hist_d;
    logic [SUM_W-1:0]                sum_q, sum_d;
    logic [2:0]                      fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        if (i_flush) begin
            hist_d = '0;
            sum_d  = '0;
            fill_d = '0;
        end
        if (i_push) begin
            // Empty slots hold zero, so subtracting the oldest slot is
            // correct before the history is full as well.
            sum_d  = sum_d - SUM_W'(hist_d[SUM_DEPTH-1]) + SUM_W'(i_period);
            hist_d = {hist_d[SUM_DEPTH-2:0], i_period};
            if (fill_d != FULL_C) begin
                fill_d = fill_d + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hist_q <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    assign o_sum  = sum_q;
    assign o_full = (fill_q == FULL_C);

endmodule

// File: rtl/hall_speed_meter.sv
// hall_speed_meter: commutation-interval meter for a BLDC controller.
// Decodes the hall sector on each hall edge, tracks direction, measures the
// cycle interval between edges and keeps a six-interval running sum.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_hall           : registered hall levels {C,B,A}
//   i_hall_edge      : per-channel edge strobes; any bit set is one event
//   o_sector         : decoded sector 0..5, 7 = unknown
//   o_dir            : 1 = forward, 0 = reverse
//   o_period         : cycles between the last two accepted edges, 0 = unknown
//   o_period_valid   : one-cycle strobe when o_period updates
//   o_period_sum     : sum of the last six accepted periods
//   o_sum_valid      : high while the sum covers six same-direction periods
//   o_stall          : high from timeout until the next legal edge
//   o_seq_err        : one-cycle strobe on an illegal code or sector skip
module hall_speed_meter
    import hall_speed_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 10_000_000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [2:0]         i_hall,
    input  logic [2:0]         i_hall_edge,
    output logic [2:0]         o_sector,
    output logic               o_dir,
    output logic [CNT_W-1:0]   o_period,
    output logic               o_period_valid,
    output logic [CNT_W+2:0]   o_period_sum,
    output logic               o_sum_valid,
    output logic               o_stall,
    output logic               o_seq_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       sector_q, sector_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             stall_q, stall_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             hall_event;
    logic [2:0]       new_sector;
    logic             is_fwd;
    logic             is_rev;
    logic             hist_flush;
    logic             hist_push;

    assign hall_event = |i_hall_edge;
    assign new_sector = hall_decode(i_hall);
    assign is_fwd     = (new_sector == sector_next(sector_q));
    assign is_rev     = (new_sector == sector_prev(sector_q));

    always_comb begin
        state_d        = state_q;
        sector_d       = sector_q;
        dir_d          = dir_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stall_d        = stall_q;
        seq_err_d      = 1'b0;
        hist_flush     = 1'b0;
        hist_push      = 1'b0;

        // Counter value in an event cycle equals the distance to the
        // previous event, since it reloads to 1 in every event cycle.
        if (hall_event) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == TIMEOUT_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (hall_event) begin
            if (new_sector == SECTOR_UNKNOWN) begin
                seq_err_d  = 1'b1;
                sector_d   = SECTOR_UNKNOWN;
                state_d    = ST_IDLE;
                hist_flush = 1'b1;
            end else begin
                stall_d  = 1'b0;
                sector_d = new_sector;
                if (state_q == ST_IDLE) begin
                    state_d = ST_SYNC;
                end else if (is_fwd || is_rev) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    state_d        = ST_RUN;
                    hist_push      = 1'b1;
                    // Direction reversal: old history is flushed and the
                    // current period becomes the first entry.
                    if (is_fwd != dir_q) begin
                        dir_d      = is_fwd;
                        hist_flush = 1'b1;
                    end
                end else begin
                    seq_err_d  = 1'b1;
                    state_d    = ST_SYNC;
                    hist_flush = 1'b1;
                end
            end
        end else if (cnt_q == TIMEOUT_C) begin
            stall_d    = 1'b1;
            state_d    = ST_IDLE;
            period_d   = '0;
            hist_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            sector_q       <= SECTOR_UNKNOWN;
            dir_q          <= 1'b1;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stall_q        <= 1'b0;
            seq_err_q      <= 1'b0;
            cnt_q          <= CNT_ONE;
        end else begin
            state_q        <= state_d;
            sector_q       <= sector_d;
            dir_q          <= dir_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stall_q        <= stall_d;
            seq_err_q      <= seq_err_d;
            cnt_q          <= cnt_d;
        end
    end

    period_sum6 #(
        .CNT_W (CNT_W)
    ) u_period_sum6 (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_flush  (hist_flush),
        .i_push   (hist_push),
        .i_period (cnt_q),
        .o_sum    (o_period_sum),
        .o_full   (o_sum_valid)
    );

    assign o_sector       = sector_q;
    assign o_dir          = dir_q;
    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_stall        = stall_q;
    assign o_seq_err      = seq_err_q;

endmodule

// File: doc/hall_speed_meter.md
Name: hall_speed_meter

Overview:
Commutation-interval meter fed by the three hall-channel edge detectors of the BLDC controller. On every hall edge it decodes the electrical sector, checks the sequence and sets the rotation direction. It measures the clock-cycle interval since the previous edge and keeps a 6-interval (one electrical revolution) running sum for the PI speed loop. It also flags stalls and illegal hall sequences.

Parameters:
CNT_W, 24, width of the interval counter and of o_period
TIMEOUT, 10_000_000, cycles without an edge before a stall is declared; must be < 2^CNT_W

Ports:
i_clk  input  1  system clock; the only clock in the block
i_reset  input  1  asynchronous, active-high reset
i_hall  input  3  registered hall levels {C,B,A}, sampled in the same cycle as i_hall_edge
i_hall_edge  input  3  per-channel posedge|negedge strobes, one cycle wide
o_sector  output  3  decoded sector 0..5; 7 = unknown
o_dir  output  1  1 = forward, 0 = reverse
o_period  output  CNT_W  cycles between the last two accepted edges; 0 = unknown
o_period_valid  output  1  one-cycle strobe when o_period updates
o_period_sum  output  CNT_W+3  sum of the last 6 accepted periods
o_sum_valid  output  1  level; high while o_period_sum covers 6 same-direction periods
o_stall  output  1  level; high from timeout until the next legal edge
o_seq_err  output  1  one-cycle strobe on an illegal code or a sector skip

Behaviour:
- Reset values (asynchronous): o_sector=7, o_dir=1, o_period=0, o_period_valid=0, o_period_sum=0, o_sum_valid=0, o_stall=0, o_seq_err=0, state IDLE, counter=1, fill=0.
- Event: any bit of i_hall_edge high. Several bits high in one cycle count as a single event.
- Decode table {C,B,A}->sector: 001->0, 011->1, 010->2, 110->3, 100->4, 101->5. Codes 000 and 111 are illegal.
- Counter: +1 per cycle, saturating at TIMEOUT; reloads to 1 in every event cycle. The interval reported for an event therefore equals the cycle distance between the two events.
- FSM states: IDLE (no reference edge), SYNC (reference edge held, interval unknown), RUN.
- Illegal code at event (any state): o_seq_err pulse, o_sector=7, go to IDLE, fill=0, o_sum_valid=0.
- IDLE + legal event: latch sector, go to SYNC. No period is reported.
- SYNC/RUN + legal event:
  - new sector = prev+1 mod 6: forward.
  - new sector = prev-1 mod 6: reverse.
  - same sector or a jump of 2..3: o_seq_err pulse, latch the new sector, go to SYNC. No period is reported; fill=0.
  - Adjacent sector: o_period <= counter, o_period_valid pulse, state RUN.
- Direction change (new dir != o_dir on an adjacent-sector event): o_dir updates, history is flushed (fill=0, sum=0), then the current period is pushed.
- 6-deep period FIFO (shift register):
  - Each push adds the new period and subtracts the oldest.
  - fill saturates at 6; o_sum_valid=1 when fill==6.
  - Sum width is CNT_W+3, so it never overflows.
- Timing: all outputs register on the cycle after the event (latency 1). o_period_valid and o_seq_err are high for exactly one cycle.
- Timeout (counter reaches TIMEOUT with no event):
  - o_stall=1, state IDLE, o_period=0, sum=0, fill=0, o_sum_valid=0.
  - o_sector keeps its last value.
  - The counter holds at TIMEOUT.
- Stall clear: o_stall clears on the next legal event. That event acts as the IDLE reference (state SYNC).
- Event and timeout in the same cycle: the event wins; no stall is raised.
- Reset mid-operation: immediate return to reset values; partial FIFO contents are discarded.

Decomposition:
- Shared package: the hall decode table, the SECTOR_UNKNOWN=7 constant, and the FSM state encodings (IDLE/SYNC/RUN).
- One natural sub-module: period_sum6, the 6-deep shift register with running sum, fill count, flush and push inputs.
- Decode, FSM and counter stay in the top level.

Test Plan:
1. Reset, then forward sequence 001,011,010,110,100,101,001 at 1000-cycle spacing:
   - first event: o_period_valid stays 0.
   - next 6 events: o_period=1000 and o_dir=1 each time.
   - after the 6th period: o_period_sum=6000, o_sum_valid=1.
2. From RUN forward at 1000-cycle spacing, drive sector 3 then sector 2 500 cycles later: o_dir=0, o_period=500, o_period_sum=500, o_sum_valid=0.
3. Drive hall=111 with an edge strobe: o_seq_err pulses 1 cycle, o_sector=7, next legal event reports no period.
4. Jump from sector 1 to sector 4: o_seq_err pulses, o_period unchanged, o_sector=4; the next adjacent event 800 cycles later gives o_period=800.
5. TIMEOUT=5000, no edges after RUN: o_stall=1 exactly 5000 cycles after the last event, o_period=0.
   - event landing on the timeout cycle: o_stall stays 0.
6. Two i_hall_edge bits high together:
   - counted as one event.
   - assert i_reset mid-FIFO fill=3: all outputs return to reset values asynchronously.
